piso_tx_scheduler: RTL
======================

Name: piso_tx_scheduler

Overview:
Round-robin scheduler sharing one 4-bit-class parallel-in/serial-out right-shift serializer between NUM_REQ requesters.
- Accepts one parallel word per granted request over a valid/ready handshake.
- Loads the word into the shift datapath and sequences LSB-first shifting with a bit counter.
- Frames the serial stream with first/last/source markers.
- Sits between parallel producers and a single-wire serial link.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
DATA_W, 4, word width and bits per frame (≥2)
GAP_CYCLES, 1, idle cycles inserted after each frame (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  NUM_REQ  per-requester word available
req_data  in  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot handshake grant; transfer when req_valid[i] & req_ready[i]
s_out  out  1  serial data, LSB first
s_valid  out  1  s_out carries a frame bit this cycle
s_first  out  1  first bit of frame
s_last  out  1  final bit of frame
s_src  out  $clog2(NUM_REQ)  index of requester owning the current frame
busy  out  1  state != IDLE

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high.
  - On reset: state=IDLE, shift register=0, bit counter=0, RR pointer=0, s_src=0.
  - All outputs are 0 during and after reset, including req_ready.
- FSM states: IDLE, SHIFT, GAP. PAR is added only under the optional feature.
- IDLE:
  - req_ready is combinational: one-hot to the first i with req_valid[i], searching from the pointer upward with wrap.
  - No valid requests → req_ready=0 and state stays IDLE.
  - On handshake edge: shift register ← req_data[i], s_src ← i, pointer ← (i+1) mod NUM_REQ, counter ← 0, state → SHIFT.
- SHIFT:
  - Combinational outputs:
    - s_out = shift_reg[0]
    - s_valid = 1
    - s_first = (cnt==0)
    - s_last = (cnt==DATA_W-1) and no parity.
  - Each edge: shift_reg ← shift_reg>>1 (zero fill), cnt++.
  - At cnt==DATA_W-1: go to GAP, or to IDLE if GAP_CYCLES==0.
  - req_ready=0 throughout.
- GAP: s_valid=0. Count GAP_CYCLES cycles, then go to IDLE. req_ready=0.
- Latency: first bit appears in the cycle after the handshake edge.
  - Frame period = 1 (IDLE handshake) + DATA_W + GAP_CYCLES cycles.
  - There is always at least one non-valid cycle between frames.
- Boundaries:
  - req_valid may drop without a handshake; no effect.
  - req_data must be stable only in the handshake cycle.
  - Simultaneous requests: pointer priority.
  - A continuously valid requester is served at most once per NUM_REQ grants when all requesters are active.
  - Pointer wraps NUM_REQ-1 → 0.
  - Reset mid-frame: frame abandoned immediately, no further bits, pointer returns to 0.
  - The bit counter is sized to $clog2(DATA_W+1) bits so the parity state fits.

Optional Feature:
Macro PISO_TX_PARITY_EN.
- Defined:
  - After the DATA_W data bits, the FSM enters PAR for one cycle.
  - In PAR: s_out = even parity (XOR) of the captured word, s_valid=1, s_last=1. s_last is 0 on the last data bit.
  - The parity bit is computed and registered at the handshake.
  - Frame period grows by 1.
- Undefined: no PAR state, no parity register. s_last marks the last data bit.

Decomposition:
- Package piso_tx_pkg:
  - state enum (IDLE, SHIFT, GAP, PAR)
  - function for round-robin next-grant one-hot
  - SRC_W/CNT_W width helper constants
- Sub-module piso_shift_dp: DATA_W shift register with load, shift_en, serial out bit 0, zero fill, async reset.
- Scheduler drives load = handshake and shift_en = (state==SHIFT).

Test Plan:
All tests use defaults (NUM_REQ=4, DATA_W=4, GAP_CYCLES=1) unless noted.
1. Reset; req_valid=4'b0001, req_data[3:0]=4'b1011 → s_out 1,1,0,1 on four consecutive s_valid cycles; s_first on bit 1, s_last on bit 4, s_src=0; then 1 GAP cycle and 1 IDLE cycle.
2. req_valid=4'b1111 held, pointer 0 → grants 0,1,2,3,0; frames start 6 cycles apart; s_src sequence 0,1,2,3,0.
3. req_valid=4'b1010 held → s_src alternates 1,3,1,3; req0/req2 never granted.
4. Reset asserted after 2 bits of a frame with data 4'b1100 → s_valid=0 and busy=0 same cycle. After release with req_valid=4'b1111, first grant is to req0.
5. PISO_TX_PARITY_EN defined, data 4'b0111 → s_out 1,1,1,0,1; s_last only on the 5th bit; period 7 cycles.
6. GAP_CYCLES=0, req_valid=4'b0001 held → frames 5 cycles apart, exactly one s_valid=0 cycle between frames.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the round-robin PISO transmit scheduler.
// Widths derive from the requester count and word size of each instance.
package piso_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      PAR   = 2'd3
   } state_t;

   localparam int unsigned MAX_REQ = 32;
   localparam int unsigned GAP_W   = 4;

   function automatic int unsigned src_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Counter needs one spare code so the parity beat fits after the data bits.
   function automatic int unsigned cnt_w(input int unsigned d);
      return $clog2(d + 1);
   endfunction

   // One-hot grant to the first valid requester at or above ptr, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] valid,
                                                   input int unsigned         ptr,
                                                   input int unsigned         n);
      logic [MAX_REQ-1:0] g;
      logic               found;
      int unsigned        idx;
      g     = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if (k < n && !found && valid[idx[4:0]]) begin
            g[idx[4:0]] = 1'b1;
            found       = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/piso_tx_scheduler_shift_dp.sv
// Right-shift serializer datapath: parallel load, LSB-first shift with zero fill.
module piso_shift_dp #(
   parameter int unsigned DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              shift_en,
   output logic              s_bit
);

   logic [DATA_W-1:0] sr_q;
   logic [DATA_W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = load_data;
      end else if (shift_en) begin
         sr_d = {1'b0, sr_q[DATA_W-1:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign s_bit = sr_q[0];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one PISO serializer among NUM_REQ requesters.
// Define PISO_TX_PARITY_EN to append an even-parity bit to each frame.
module piso_tx_scheduler
   import piso_tx_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       s_out,
   output logic                       s_valid,
   output logic                       s_first,
   output logic                       s_last,
   output logic [$clog2(NUM_REQ)-1:0] s_src,
   output logic                       busy
);

   localparam int unsigned SRC_W = src_w(NUM_REQ);
   localparam int unsigned CNT_W = cnt_w(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   ptr_q, ptr_d;
   logic [SRC_W-1:0]   src_q, src_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
`ifdef PISO_TX_PARITY_EN
   logic               par_q, par_d;
`endif

   logic [MAX_REQ-1:0] grant_full;
   logic [SRC_W-1:0]   grant_idx;
   logic [DATA_W-1:0]  sel_word;
   logic               hs;
   logic               dp_bit;

   assign grant_full = rr_grant(MAX_REQ'(req_valid), 32'(ptr_q), NUM_REQ);

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (grant_full[i]) grant_idx = SRC_W'(i);
      end
   end

   // Grant is offered only while idle and never while reset is held.
   assign req_ready = (state_q == IDLE && !reset) ? grant_full[NUM_REQ-1:0] : '0;
   assign hs        = |(req_valid & req_ready);
   assign sel_word  = req_data[grant_idx*DATA_W +: DATA_W];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      src_d   = src_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
`ifdef PISO_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (hs) begin
               ptr_d   = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
               src_d   = grant_idx;
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef PISO_TX_PARITY_EN
               par_d   = ^sel_word;
`endif
            end
         end
         SHIFT: begin
            cnt_d = cnt_q + CNT_W'(1);
            gap_d = '0;
            if (cnt_q == CNT_LAST) begin
`ifdef PISO_TX_PARITY_EN
               state_d = PAR;
`else
               state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
`endif
            end
         end
`ifdef PISO_TX_PARITY_EN
         PAR: begin
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
         end
`endif
         GAP: begin
            gap_d = gap_q + GAP_W'(1);
            if (gap_q == GAP_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         src_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
`ifdef PISO_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
`ifdef PISO_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   piso_shift_dp #(.DATA_W(DATA_W)) u_shift_dp (
      .clk       (clk),
      .reset     (reset),
      .load      (hs),
      .load_data (sel_word),
      .shift_en  (state_q == SHIFT),
      .s_bit     (dp_bit)
   );

   assign s_first = (state_q == SHIFT) && (cnt_q == '0);
   assign s_src   = src_q;
   assign busy    = (state_q != IDLE);

`ifdef PISO_TX_PARITY_EN
   assign s_valid = (state_q == SHIFT) || (state_q == PAR);
   assign s_out   = (state_q == SHIFT) ? dp_bit : ((state_q == PAR) ? par_q : 1'b0);
   assign s_last  = (state_q == PAR);
`else
   assign s_valid = (state_q == SHIFT);
   assign s_out   = (state_q == SHIFT) ? dp_bit : 1'b0;
   assign s_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`endif

endmodule
